// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and sweep FSM state encoding
package rf_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_AWIDTH = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_sweep_ctl.sv
// rtl/rf_sweep_ctl.sv - IDLE/SWEEP controller that walks every array entry to zero
module rf_sweep_ctl
    import rf_pkg::*;
#(
    parameter int AWIDTH = RF_AWIDTH
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              sweep_we_o,
    output logic              start_o,
    output logic [AWIDTH-1:0] sweep_addr_o
);

    rf_state_e         state_q, state_d;
    logic [AWIDTH-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_o     = 1'b0;
        sweep_we_o = 1'b0;
        start_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    start_o = 1'b1;
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                busy_o     = 1'b1;
                sweep_we_o = 1'b1;
                idx_d      = idx_q + AWIDTH'(1);
                // Last entry is written on this edge; idx wraps back to 0.
                if (&idx_q) state_d = ST_IDLE;
            end
        endcase
    end

    assign sweep_addr_o = idx_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R1W register file with bypass, pending scoreboard and clear sweep
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int AWIDTH   = RF_AWIDTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic              RegWrite,
    input  logic [AWIDTH-1:0] WN,
    input  logic [WIDTH-1:0]  WD,
    input  logic              Reserve,
    input  logic [AWIDTH-1:0] RNres,
    input  logic [AWIDTH-1:0] RN1,
    input  logic [AWIDTH-1:0] RN2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              sweep_we, sweep_start;
    logic [AWIDTH-1:0] sweep_addr;
    logic              wr_en, host_wr, host_res;
    logic [AWIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    rf_sweep_ctl #(.AWIDTH(AWIDTH)) u_sweep (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (clear),
        .busy_o       (busy),
        .sweep_we_o   (sweep_we),
        .start_o      (sweep_start),
        .sweep_addr_o (sweep_addr)
    );

    assign host_wr  = !busy && RegWrite && !(ZERO_REG != 0 && WN == '0);
    assign host_res = !busy && Reserve && !(ZERO_REG != 0 && RNres == '0);

    always_comb begin
        wr_en   = host_wr;
        wr_addr = WN;
        wr_data = WD;
        if (busy) begin
            wr_en   = sweep_we;
            wr_addr = sweep_addr;
            wr_data = '0;
        end
    end

    // Storage has no reset; the sweep is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        pend_d = pend_q;
        if (sweep_start) begin
            pend_d = '0;
        end else begin
            if (host_wr)  pend_d[WN]    = 1'b0;
            if (host_res) pend_d[RNres] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    always_comb begin
        RD1   = '0;
        pend1 = 1'b0;
        if (!busy && !(ZERO_REG != 0 && RN1 == '0)) begin
            if (BYPASS != 0 && RegWrite && WN == RN1) begin
                RD1 = WD;
            end else begin
                RD1   = mem_q[RN1];
                pend1 = pend_q[RN1];
            end
        end
    end

    always_comb begin
        RD2   = '0;
        pend2 = 1'b0;
        if (!busy && !(ZERO_REG != 0 && RN2 == '0)) begin
            if (BYPASS != 0 && RegWrite && WN == RN2) begin
                RD2 = WD;
            end else begin
                RD2   = mem_q[RN2];
                pend2 = pend_q[RN2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset, clear, RegWrite, Reserve;
    logic [4:0]  WN, RNres, RN1, RN2;
    logic [31:0] WD;
    logic        busy, busy_nb;
    logic [31:0] RD1, RD2, RD1_nb, RD2_nb;
    logic        pend1, pend2, pend1_nb, pend2_nb;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy),
        .RegWrite(RegWrite), .WN(WN), .WD(WD), .Reserve(Reserve), .RNres(RNres),
        .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2), .pend1(pend1), .pend2(pend2)
    );

    reg_file_sb #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_nb),
        .RegWrite(RegWrite), .WN(WN), .WD(WD), .Reserve(Reserve), .RNres(RNres),
        .RN1(RN1), .RN2(RN2), .RD1(RD1_nb), .RD2(RD2_nb), .pend1(pend1_nb), .pend2(pend2_nb)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; clear = 1'b0; RegWrite = 1'b0; Reserve = 1'b0;
        WN = '0; WD = '0; RNres = '0; RN1 = 5'd7; RN2 = 5'd7;
        #3;
        total++;
        if (busy !== 1'b1 || RD1 !== 32'd0 || pend1 !== 1'b0)
            $display("FAIL reset_state busy=%b RD1=%h pend1=%b required 1/0/0", busy, RD1, pend1);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== 32) $display("FAIL reset_busy_len got %0d edges required 32", n);
        else pass_cnt++;
        #1;
        total++;
        if (RD1 !== 32'd0 || pend1 !== 1'b0)
            $display("FAIL reset_read7 RD1=%h pend1=%b required 0/0", RD1, pend1);
        else pass_cnt++;
    endtask

    task automatic test_write_bypass();
        RegWrite = 1'b1; WN = 5'd5; WD = 32'hDEADBEEF; RN1 = 5'd5;
        #1;
        total++;
        if (RD1 !== 32'hDEADBEEF) $display("FAIL bypass_rd1 got %h required deadbeef", RD1);
        else pass_cnt++;
        total++;
        if (RD1_nb !== 32'd0) $display("FAIL nobypass_old got %h required 0", RD1_nb);
        else pass_cnt++;
        tick();
        RegWrite = 1'b0;
        #1;
        total++;
        if (RD1 !== 32'hDEADBEEF || RD1_nb !== 32'hDEADBEEF)
            $display("FAIL write_array got %h/%h required deadbeef", RD1, RD1_nb);
        else pass_cnt++;
    endtask

    task automatic test_reserve();
        Reserve = 1'b1; RNres = 5'd9;
        tick();
        Reserve = 1'b0; RN2 = 5'd9;
        #1;
        total++;
        if (pend2 !== 1'b1) $display("FAIL reserve_pend got %b required 1", pend2);
        else pass_cnt++;
        tick();
        RegWrite = 1'b1; WN = 5'd9; WD = 32'h0000_55AA;
        #1;
        total++;
        if (pend2 !== 1'b0 || pend2_nb !== 1'b1)
            $display("FAIL write_cycle_pend got %b/%b required 0/1", pend2, pend2_nb);
        else pass_cnt++;
        tick();
        RegWrite = 1'b0;
        #1;
        total++;
        if (pend2 !== 1'b0 || RD2 !== 32'h0000_55AA)
            $display("FAIL write_clears_pend pend2=%b RD2=%h required 0/000055aa", pend2, RD2);
        else pass_cnt++;
    endtask

    task automatic test_same_reg();
        Reserve = 1'b1; RNres = 5'd3; RegWrite = 1'b1; WN = 5'd3; WD = 32'hCAFE0003;
        tick();
        Reserve = 1'b0; RegWrite = 1'b0; RN1 = 5'd3;
        #1;
        total++;
        if (pend1 !== 1'b1 || RD1 !== 32'hCAFE0003)
            $display("FAIL same_reg pend1=%b RD1=%h required 1/cafe0003", pend1, RD1);
        else pass_cnt++;
    endtask

    task automatic test_diff_reg();
        Reserve = 1'b1; RNres = 5'd4; RegWrite = 1'b1; WN = 5'd6; WD = 32'h0000_0606;
        tick();
        Reserve = 1'b0; RegWrite = 1'b0; RN1 = 5'd4; RN2 = 5'd6;
        #1;
        total++;
        if (pend1 !== 1'b1 || pend2 !== 1'b0 || RD2 !== 32'h0000_0606)
            $display("FAIL diff_reg pend1=%b pend2=%b RD2=%h required 1/0/00000606", pend1, pend2, RD2);
        else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WN = 5'd0; WD = 32'h1234; Reserve = 1'b1; RNres = 5'd0; RN1 = 5'd0;
        #1;
        total++;
        if (RD1 !== 32'd0 || pend1 !== 1'b0)
            $display("FAIL zero_same_cycle RD1=%h pend1=%b required 0/0", RD1, pend1);
        else pass_cnt++;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        #1;
        total++;
        if (RD1 !== 32'd0 || pend1 !== 1'b0 || RD1_nb !== 32'd0)
            $display("FAIL zero_after RD1=%h pend1=%b RD1_nb=%h required 0/0/0", RD1, pend1, RD1_nb);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        RegWrite = 1'b1; WN = 5'd5; WD = 32'hFFFF_FFFF;
        Reserve = 1'b1; RNres = 5'd12; RN1 = 5'd3;
        #1;
        total++;
        if (busy !== 1'b1 || RD1 !== 32'd0 || pend1 !== 1'b0)
            $display("FAIL clear_busy busy=%b RD1=%h pend1=%b required 1/0/0", busy, RD1, pend1);
        else pass_cnt++;
        n = 0;
        while (busy && n < 40) begin
            clear = (n == 5);
            tick();
            n++;
        end
        clear = 1'b0; RegWrite = 1'b0; Reserve = 1'b0;
        total++;
        if (n !== 32) $display("FAIL clear_busy_len got %0d edges required 32", n);
        else pass_cnt++;
        for (int r = 0; r < 32; r++) begin
            RN1 = 5'(r);
            #1;
            total++;
            if (RD1 !== 32'd0 || pend1 !== 1'b0)
                $display("FAIL cleared_r%0d RD1=%h pend1=%b required 0/0", r, RD1, pend1);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL mid_reset_busy got %b required 1", busy);
        else pass_cnt++;
        #1;
        reset = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== 32) $display("FAIL mid_reset_len got %0d edges required 32", n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_reserve();
        test_same_reg();
        test_diff_reg();
        test_zero_reg();
        test_clear();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
